pad_counter_ctrl: RTL
=====================

Name: pad_counter_ctrl

Overview:
- Controller that sequences the pad-visible event counter in chip_core.
- Accepts start/stop/load/clear commands over a valid/ready handshake.
- Divides clk by a programmable prescaler into count ticks and stops at a programmable limit (one-shot) or reloads to zero (auto-reload).
- count_out drives the output and bidir pad buses; done and wrap are status for the surrounding core.

Parameters:
- WIDTH, 8, counter and limit width (set to NUM_BIDIR_PADS at instantiation).
- PRESCALE_W, 4, prescaler width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  input  2  00 START, 01 STOP, 10 LOAD, 11 CLEAR.
- cmd_data  input  WIDTH  new limit, used by LOAD only.
- prescale  input  PRESCALE_W  tick period minus 1, compared live.
- auto_reload  input  1  1 = reload to 0 at limit; 0 = one-shot.
- count_out  output  WIDTH  current count register.
- running  output  1  state == RUN.
- done  output  1  one-cycle pulse: one-shot run reached the limit.
- wrap  output  1  one-cycle pulse: auto-reload occurred.

Behaviour:
- Reset values (rst_n low at a clk edge):
  - state IDLE, count 0, limit all-ones, presc_cnt 0.
  - done 0, wrap 0, running 0, cmd_ready 1.
  - Reset mid-run aborts immediately with no done or wrap pulse.
- FSM states IDLE, RUN, DONE:
  - cmd_ready = (state != DONE), combinational from state.
  - DONE lasts exactly 1 cycle, then IDLE. done = (state == DONE).
- Commands, effective at the accepting edge:
  - START: in IDLE, state goes to RUN and presc_cnt to 0; count is unchanged, so a run after STOP resumes. In RUN, no effect.
  - STOP: RUN goes to IDLE; count and presc_cnt hold. No effect in IDLE.
  - LOAD: limit <= cmd_data in any state. The compare in the same cycle uses the old limit.
  - CLEAR: count <= 0 and presc_cnt <= 0; state unchanged.
- Prescaler, in RUN only:
  - tick = (presc_cnt == prescale).
  - On tick, presc_cnt <= 0; otherwise presc_cnt <= presc_cnt + 1 (mod 2^PRESCALE_W).
  - prescale = 0 gives a tick every RUN cycle.
  - The first tick is prescale+1 cycles after the START edge.
- Count update on tick:
  - nxt = count + 1 (mod 2^WIDTH).
  - If nxt != limit: count <= nxt.
  - If nxt == limit and auto_reload = 1: count <= 0, wrap <= 1 for the next cycle, stay in RUN.
  - If nxt == limit and auto_reload = 0: count <= limit, state goes to DONE.
- Limit arithmetic:
  - The compare is equality only.
  - limit = 0 means a period of 2^WIDTH ticks.
  - A limit at or below the current count wraps through 2^WIDTH − 1 → 0 before matching.
- Priority when a command coincides with a tick:
  - STOP beats tick: no count change, no done.
  - CLEAR beats tick: count 0, no terminal check.
  - LOAD and tick both take effect, with the compare using the old limit.
- Idle behaviour:
  - In IDLE and DONE, prescale and auto_reload changes have no effect.
  - In IDLE and DONE, count holds.

Test Plan:
1. Reset, then LOAD 5, auto_reload=0, prescale=0, START → count_out 1,2,3,4,5 on the 5 consecutive cycles after the START edge; done high for 1 cycle on the cycle count reaches 5; cmd_ready low that cycle; then IDLE with count 5.
2. LOAD 3, auto_reload=1, prescale=2, START → count increments every 3 cycles: 1, 2, 0 (wrap pulse), 1, 2, 0 (wrap pulse); running stays 1; done never asserts.
3. Running with prescale=0: STOP, wait 4 cycles, START → count frozen for 4 cycles, then resumes from the held value; STOP issued on the terminal-tick cycle → no done, count = limit−1.
4. CLEAR while RUN at count 7 → count 0 at the next edge, state still RUN; CLEAR in IDLE → count 0, running 0.
5. LOAD 0, WIDTH=8, prescale=0, one-shot START → done after 256 ticks with count_out 0. Separately, LOAD 2 while count=6 in RUN → count wraps 255→0→1→2, then done.
6. Assert rst_n low mid-RUN with wrap pending → next cycle count 0, running 0, done 0, wrap 0, cmd_ready 1, limit 0xFF.

Source files
------------

// File: rtl/pad_counter_ctrl.sv
// Command-driven prescaled event counter controller for the chip_core pad counter.
// One-shot runs stop at the limit and pulse done; auto-reload runs return to zero and pulse wrap.
module pad_counter_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [WIDTH-1:0]      cmd_data,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  auto_reload,
    output logic [WIDTH-1:0]      count_out,
    output logic                  running,
    output logic                  done,
    output logic                  wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  wrap_q,  wrap_d;

    logic                  accept;
    logic                  tick;
    logic [WIDTH-1:0]      count_inc;

    assign cmd_ready = (state_q != ST_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign tick      = (state_q == ST_RUN) && (presc_q == prescale);
    assign count_inc = count_q + WIDTH'(1);

    // Next-state: commands first, then prescaler/count only when no STOP or CLEAR preempts the tick
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;

        if (accept && (cmd_op == OP_LOAD)) begin
            limit_d = cmd_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && (cmd_op == OP_START)) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end else if (accept && (cmd_op == OP_CLEAR)) begin
                    count_d = '0;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                if (accept && (cmd_op == OP_STOP)) begin
                    state_d = ST_IDLE;
                end else if (accept && (cmd_op == OP_CLEAR)) begin
                    count_d = '0;
                    presc_d = '0;
                end else if (tick) begin
                    presc_d = '0;
                    if (count_inc != limit_q) begin
                        count_d = count_inc;
                    end else if (auto_reload) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = limit_q;
                        state_d = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + PRESCALE_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            limit_q <= '1;
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            presc_q <= presc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_out = count_q;
    assign running   = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign wrap      = wrap_q;

endmodule
